// File: rtl/half_adder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | half_adder_pkg : default lane count and counter width                |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package half_adder_pkg;
   localparam int HA_WIDTH = 1;
   localparam int HA_CNT_W = 16;
endpackage : half_adder_pkg
`default_nettype wire

// File: rtl/half_adder_core_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | half_adder_core_if : operand, result and status bundle               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface half_adder_core_if
   import half_adder_pkg::*;
#(
   parameter int WIDTH = HA_WIDTH,
   parameter int CNT_W = HA_CNT_W
);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             in_valid;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] carry;
   logic [WIDTH-1:0] sum_q;
   logic [WIDTH-1:0] carry_q;
   logic             out_valid;
   logic [CNT_W-1:0] carry_cnt;

   modport master (
      output a, b, in_valid,
      input  sum, carry, sum_q, carry_q, out_valid, carry_cnt
   );

   modport slave (
      input  a, b, in_valid,
      output sum, carry, sum_q, carry_q, out_valid, carry_cnt
   );
endinterface : half_adder_core_if
`default_nettype wire

// File: rtl/half_adder_bit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | half_adder_bit : single-lane combinational half adder                |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module half_adder_bit (
   input  wire logic a_i,
   input  wire logic b_i,
   output logic      sum_o,
   output logic      carry_o
);
   assign sum_o   = a_i ^ b_i;
   assign carry_o = a_i & b_i;
endmodule : half_adder_bit
`default_nettype wire

// File: rtl/half_adder_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | half_adder_core : WIDTH independent half-adder lanes with registered |
// | copy, valid flag and saturating carry-event counter                  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module half_adder_core
   import half_adder_pkg::*;
#(
   parameter int WIDTH = HA_WIDTH,
   parameter int CNT_W = HA_CNT_W
) (
   input  wire logic     clk,
   input  wire logic     rst_n,
   half_adder_core_if.slave bus
);
   localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] w_carry;

   logic [WIDTH-1:0] sum_q,       sum_d;
   logic [WIDTH-1:0] carry_q,     carry_d;
   logic             valid_q,     valid_d;
   logic [CNT_W-1:0] carry_cnt_q, carry_cnt_d;

   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      half_adder_bit u_bit (
         .a_i     (bus.a[i]),
         .b_i     (bus.b[i]),
         .sum_o   (w_sum[i]),
         .carry_o (w_carry[i])
      );
   end

   always_comb begin
      sum_d       = sum_q;
      carry_d     = carry_q;
      valid_d     = 1'b0;
      carry_cnt_d = carry_cnt_q;
      if (bus.in_valid) begin
         sum_d   = w_sum;
         carry_d = w_carry;
         valid_d = 1'b1;
         // Counter sticks at all-ones rather than wrapping.
         if ((|w_carry) && (carry_cnt_q != C_CNT_MAX)) begin
            carry_cnt_d = carry_cnt_q + C_CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q       <= '0;
         carry_q     <= '0;
         valid_q     <= 1'b0;
         carry_cnt_q <= '0;
      end else begin
         sum_q       <= sum_d;
         carry_q     <= carry_d;
         valid_q     <= valid_d;
         carry_cnt_q <= carry_cnt_d;
      end
   end

   assign bus.sum       = w_sum;
   assign bus.carry     = w_carry;
   assign bus.sum_q     = sum_q;
   assign bus.carry_q   = carry_q;
   assign bus.out_valid = valid_q;
   assign bus.carry_cnt = carry_cnt_q;
endmodule : half_adder_core
`default_nettype wire

// File: tb/tb_half_adder_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_half_adder_core : directed checks on 1-lane, 4-lane and 2-bit     |
// | counter instances                                                    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_half_adder_core;
   logic clk = 1'b0;
   logic rst_n;
   int   vectors     = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   half_adder_core_if #(.WIDTH(1), .CNT_W(16)) if1 ();
   half_adder_core_if #(.WIDTH(4), .CNT_W(16)) if4 ();
   half_adder_core_if #(.WIDTH(1), .CNT_W(2))  ifs ();

   half_adder_core #(.WIDTH(1), .CNT_W(16)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
   half_adder_core #(.WIDTH(4), .CNT_W(16)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
   half_adder_core #(.WIDTH(1), .CNT_W(2))  u_duts (.clk(clk), .rst_n(rst_n), .bus(ifs));

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      logic       a_undriven;
      logic       b_undriven;
      logic [3:0] tt_a   = 4'b1100;
      logic [3:0] tt_b   = 4'b1010;
      logic [3:0] tt_sum = 4'b0110;
      logic [3:0] tt_cy  = 4'b1000;
      logic [3:0] beat_a [5];
      logic [3:0] beat_b [5];

      beat_a = '{4'b1100, 4'b0101, 4'b0001, 4'b1111, 4'b0000};
      beat_b = '{4'b1010, 4'b1010, 4'b0001, 4'b1111, 4'b1111};

      rst_n        = 1'b1;
      if1.in_valid = 1'b0;
      if4.in_valid = 1'b0;
      ifs.in_valid = 1'b0;

      // Undriven operands: outputs must follow whatever the inputs hold.
      #1;
      a_undriven = if1.a;
      b_undriven = if1.b;
      chk("undriven_sum",   16'(if1.sum),   16'(a_undriven ^ b_undriven));
      chk("undriven_carry", 16'(if1.carry), 16'(a_undriven & b_undriven));

      #1 rst_n = 1'b0;
      #1;
      chk("rst_sum_q",     16'(if1.sum_q),     16'h0);
      chk("rst_carry_q",   16'(if1.carry_q),   16'h0);
      chk("rst_out_valid", 16'(if1.out_valid), 16'h0);
      chk("rst_carry_cnt", 16'(if1.carry_cnt), 16'h0);

      // Truth table with reset held low: combinational path ignores it.
      for (int i = 0; i < 4; i++) begin
         if1.a = tt_a[3-i];
         if1.b = tt_b[3-i];
         #1;
         chk($sformatf("tt_sum_%0d", i),   16'(if1.sum),   16'(tt_sum[3-i]));
         chk($sformatf("tt_carry_%0d", i), 16'(if1.carry), 16'(tt_cy[3-i]));
         #24;
      end

      @(negedge clk);
      rst_n        = 1'b1;
      if1.a        = 1'b1;
      if1.b        = 1'b1;
      if1.in_valid = 1'b1;
      @(negedge clk);
      chk("reg_sum_q",     16'(if1.sum_q),     16'h0);
      chk("reg_carry_q",   16'(if1.carry_q),   16'h1);
      chk("reg_out_valid", 16'(if1.out_valid), 16'h1);

      if1.in_valid = 1'b0;
      if1.a        = 1'b0;
      if1.b        = 1'b1;
      @(negedge clk);
      chk("hold_out_valid", 16'(if1.out_valid), 16'h0);
      chk("hold_sum_q",     16'(if1.sum_q),     16'h0);
      chk("hold_carry_q",   16'(if1.carry_q),   16'h1);
      chk("hold_carry_cnt", 16'(if1.carry_cnt), 16'h1);

      if1.a        = 1'b1;
      if1.b        = 1'b0;
      if1.in_valid = 1'b1;
      @(negedge clk);
      chk("pre_rst_valid", 16'(if1.out_valid), 16'h1);
      chk("pre_rst_sum_q", 16'(if1.sum_q),     16'h1);

      // Asynchronous reset between edges with a beat in flight.
      if1.b = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 16'(if1.out_valid), 16'h0);
      chk("mid_rst_sum_q",     16'(if1.sum_q),     16'h0);
      chk("mid_rst_carry_q",   16'(if1.carry_q),   16'h0);
      chk("mid_rst_carry_cnt", 16'(if1.carry_cnt), 16'h0);
      chk("mid_rst_sum",       16'(if1.sum),       16'h0);
      chk("mid_rst_carry",     16'(if1.carry),     16'h1);
      @(negedge clk);
      chk("rst_wins_valid", 16'(if1.out_valid), 16'h0);
      chk("rst_wins_cnt",   16'(if1.carry_cnt), 16'h0);
      if1.in_valid = 1'b0;
      rst_n        = 1'b1;

      if4.a = 4'b1100;
      if4.b = 4'b1010;
      #1;
      chk("w4_sum",   16'(if4.sum),   16'h6);
      chk("w4_carry", 16'(if4.carry), 16'h8);

      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         if4.a        = beat_a[i];
         if4.b        = beat_b[i];
         if4.in_valid = 1'b1;
         @(negedge clk);
      end
      if4.in_valid = 1'b0;
      chk("w4_carry_cnt", 16'(if4.carry_cnt), 16'd3);
      chk("w4_sum_q",     16'(if4.sum_q),     16'hF);
      chk("w4_carry_q",   16'(if4.carry_q),   16'h0);

      ifs.a        = 1'b1;
      ifs.b        = 1'b1;
      ifs.in_valid = 1'b1;
      repeat (3) @(negedge clk);
      chk("sat_cnt_3", 16'(ifs.carry_cnt), 16'd3);
      repeat (2) @(negedge clk);
      chk("sat_cnt_5", 16'(ifs.carry_cnt), 16'd3);
      chk("sat_valid", 16'(ifs.out_valid), 16'h1);
      ifs.in_valid = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule : tb_half_adder_core
`default_nettype wire
